// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared state encoding and coin values for the vending controller
package vending_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_VEND    = 2'd2;
  localparam logic [1:0] ST_CHANGE  = 2'd3;

  localparam int COIN1_VAL = 1;
  localparam int COIN2_VAL = 2;
  localparam int COIN5_VAL = 5;

endpackage

// File: rtl/vm_stock_bank.sv
// rtl/vm_stock_bank.sv - per-item stock counters with sold-out flags and an in-stock lookup
module vm_stock_bank
  import vending_pkg::*;
#(
  parameter int NUM_ITEMS  = 4,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dec,
  input  logic [$clog2(NUM_ITEMS)-1:0] dec_idx,
  input  logic [$clog2(NUM_ITEMS)-1:0] query_idx,
  output logic                         query_nonzero,
  output logic [NUM_ITEMS-1:0]         sold_out
);

  localparam int IDX_W = $clog2(NUM_ITEMS);

  logic [STOCK_W-1:0] stock [NUM_ITEMS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (dec && dec_idx == IDX_W'(i) && stock[i] != '0)
          stock[i] <= stock[i] - STOCK_W'(1);
      end
    end
  end

  // Index matching by loop keeps out-of-range queries reading as empty.
  always_comb begin
    query_nonzero = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      sold_out[i] = (stock[i] == '0);
      if (query_idx == IDX_W'(i)) query_nonzero = (stock[i] != '0);
    end
  end

endmodule

// File: rtl/vending_machine_multi.sv
// rtl/vending_machine_multi.sv - multi-item vending FSM with credit datapath and unit change handshake
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int                       NUM_ITEMS  = 4,
  parameter int                       CREDIT_W   = 6,
  parameter int                       STOCK_W    = 4,
  parameter int                       STOCK_INIT = 2,
  parameter logic [NUM_ITEMS*8-1:0]   PRICES     = {8'd10, 8'd7, 8'd3, 8'd5}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         coin_1,
  input  logic                         coin_2,
  input  logic                         coin_5,
  input  logic                         select_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] item_sel,
  input  logic                         cancel,
  input  logic                         change_ack,
  output logic                         item_dispensed,
  output logic [$clog2(NUM_ITEMS)-1:0] item_id,
  output logic                         change_valid,
  output logic                         coin_reject,
  output logic                         vend_error,
  output logic [NUM_ITEMS-1:0]         sold_out,
  output logic [CREDIT_W-1:0]          credit,
  output logic                         busy
);

  localparam int IDX_W = $clog2(NUM_ITEMS);
  localparam int SUM_W = CREDIT_W + 1;
  localparam int CMP_W = (CREDIT_W > 8) ? CREDIT_W : 8;
  localparam logic [SUM_W-1:0] MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};

  logic [1:0]          state, state_d;
  logic [CREDIT_W-1:0] credit_d, price_q, price_d;
  logic [IDX_W-1:0]    sel_q, sel_d;
  logic                reject_d, error_d, stock_dec, in_stock, in_range, sel_ok;
  logic [3:0]          coin_sum;
  logic [SUM_W-1:0]    credit_plus;
  logic [CMP_W-1:0]    sel_price;

  vm_stock_bank #(
    .NUM_ITEMS  (NUM_ITEMS),
    .STOCK_W    (STOCK_W),
    .STOCK_INIT (STOCK_INIT)
  ) u_stock (
    .clk           (clk),
    .reset         (reset),
    .dec           (stock_dec),
    .dec_idx       (sel_q),
    .query_idx     (item_sel),
    .query_nonzero (in_stock),
    .sold_out      (sold_out)
  );

  assign coin_sum = (coin_1 ? 4'(COIN1_VAL) : 4'd0)
                  + (coin_2 ? 4'(COIN2_VAL) : 4'd0)
                  + (coin_5 ? 4'(COIN5_VAL) : 4'd0);
  assign credit_plus = {1'b0, credit} + SUM_W'(coin_sum);

  always_comb begin
    in_range  = 1'b0;
    sel_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (item_sel == IDX_W'(i)) begin
        in_range  = 1'b1;
        sel_price = CMP_W'(PRICES[i*8 +: 8]);
      end
    end
  end

  // Selection is judged on the registered credit, not including this cycle's coins.
  assign sel_ok = in_range && in_stock && (CMP_W'(credit) >= sel_price);

  always_comb begin
    state_d   = state;
    credit_d  = credit;
    sel_d     = sel_q;
    price_d   = price_q;
    reject_d  = 1'b0;
    error_d   = 1'b0;
    stock_dec = 1'b0;
    case (state)
      ST_IDLE, ST_COLLECT: begin
        if (coin_sum != 4'd0) begin
          if (credit_plus <= MAX_CREDIT) credit_d = credit_plus[CREDIT_W-1:0];
          else                           reject_d = 1'b1;
        end
        if (cancel && state == ST_COLLECT) begin
          state_d = ST_CHANGE;
        end else if (select_valid && sel_ok) begin
          state_d = ST_VEND;
          sel_d   = item_sel;
          price_d = CREDIT_W'(sel_price);
        end else begin
          error_d = select_valid;
          state_d = (credit_d != '0) ? ST_COLLECT : ST_IDLE;
        end
      end
      ST_VEND: begin
        reject_d  = (coin_sum != 4'd0);
        stock_dec = 1'b1;
        credit_d  = credit - price_q;
        state_d   = (credit_d != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        reject_d = (coin_sum != 4'd0);
        if (change_ack && credit != '0) credit_d = credit - CREDIT_W'(1);
        if (credit_d == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      credit      <= '0;
      sel_q       <= '0;
      price_q     <= '0;
      coin_reject <= 1'b0;
      vend_error  <= 1'b0;
    end else begin
      state       <= state_d;
      credit      <= credit_d;
      sel_q       <= sel_d;
      price_q     <= price_d;
      coin_reject <= reject_d;
      vend_error  <= error_d;
    end
  end

  assign item_dispensed = (state == ST_VEND);
  assign item_id        = item_dispensed ? sel_q : '0;
  assign change_valid   = (state == ST_CHANGE) && (credit != '0);
  assign busy           = (state == ST_VEND) || (state == ST_CHANGE);

endmodule

// File: tb/tb_vending_machine_multi.sv
// tb/tb_vending_machine_multi.sv - directed self-checking bench for vending_machine_multi
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_1, coin_2, coin_5, select_valid, cancel, change_ack;
  logic [1:0] item_sel;
  logic       item_dispensed, change_valid, coin_reject, vend_error, busy;
  logic [1:0] item_id;
  logic [3:0] sold_out;
  logic [5:0] credit;

  int checks = 0;
  int errors = 0;

  vending_machine_multi dut (
    .clk            (clk),
    .reset          (reset),
    .coin_1         (coin_1),
    .coin_2         (coin_2),
    .coin_5         (coin_5),
    .select_valid   (select_valid),
    .item_sel       (item_sel),
    .cancel         (cancel),
    .change_ack     (change_ack),
    .item_dispensed (item_dispensed),
    .item_id        (item_id),
    .change_valid   (change_valid),
    .coin_reject    (coin_reject),
    .vend_error     (vend_error),
    .sold_out       (sold_out),
    .credit         (credit),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    coin_1 = 0; coin_2 = 0; coin_5 = 0;
    select_valid = 0; item_sel = 2'd0; cancel = 0; change_ack = 0;
    repeat (2) cyc();
    check("rst_credit", credit, 0);
    check("rst_busy", busy, 0);
    check("rst_change_valid", change_valid, 0);
    check("rst_dispensed", item_dispensed, 0);
    check("rst_reject", coin_reject, 0);
    check("rst_error", vend_error, 0);
    check("rst_sold_out", sold_out, 4'b0000);
    reset = 1'b1;
    cyc();

    // Scenario 1: exact price, no change
    coin_2 = 1; cyc(); coin_2 = 0;
    check("s1_credit2", credit, 2);
    coin_1 = 1; cyc(); coin_1 = 0;
    coin_2 = 1; cyc(); coin_2 = 0;
    check("s1_credit5", credit, 5);
    select_valid = 1; item_sel = 2'd0; cyc(); select_valid = 0;
    check("s1_dispensed", item_dispensed, 1);
    check("s1_item_id", item_id, 0);
    check("s1_busy_vend", busy, 1);
    cyc();
    check("s1_credit_after", credit, 0);
    check("s1_change_valid", change_valid, 0);
    check("s1_disp_drop", item_dispensed, 0);
    check("s1_busy_idle", busy, 0);

    // Scenario 2: one unit of change
    coin_2 = 1; repeat (3) cyc(); coin_2 = 0;
    check("s2_credit6", credit, 6);
    select_valid = 1; item_sel = 2'd0; cyc(); select_valid = 0;
    check("s2_dispensed", item_dispensed, 1);
    cyc();
    check("s2_change_valid", change_valid, 1);
    check("s2_credit1", credit, 1);
    change_ack = 1; cyc(); change_ack = 0;
    check("s2_credit0", credit, 0);
    check("s2_change_drop", change_valid, 0);
    check("s2_busy", busy, 0);
    check("s2_sold_out", sold_out, 4'b0001);

    // Scenario 3: simultaneous coins, cancel beats select, stalled refund
    coin_5 = 1; coin_1 = 1; cyc(); coin_5 = 0; coin_1 = 0;
    check("s3_credit6", credit, 6);
    cancel = 1; select_valid = 1; item_sel = 2'd1; cyc(); cancel = 0; select_valid = 0;
    check("s3_change_valid", change_valid, 1);
    check("s3_no_dispense", item_dispensed, 0);
    check("s3_credit_hold", credit, 6);
    change_ack = 1; repeat (2) cyc(); change_ack = 0;
    check("s3_no_error", vend_error, 0);
    check("s3_credit4", credit, 4);
    repeat (2) cyc();
    check("s3_stall_credit", credit, 4);
    check("s3_stall_valid", change_valid, 1);
    change_ack = 1; repeat (3) cyc();
    check("s3_credit1", credit, 1);
    check("s3_no_dispense2", item_dispensed, 0);
    cyc(); change_ack = 0;
    check("s3_credit0", credit, 0);
    check("s3_change_drop", change_valid, 0);
    check("s3_busy", busy, 0);

    // Scenario 4: sell out item1, then refused selections
    for (int n = 0; n < 2; n++) begin
      coin_1 = 1; coin_2 = 1; cyc(); coin_1 = 0; coin_2 = 0;
      select_valid = 1; item_sel = 2'd1; cyc(); select_valid = 0;
      check("s4_dispensed", item_dispensed, 1);
      check("s4_item_id", item_id, 1);
      cyc();
      check("s4_credit0", credit, 0);
    end
    check("s4_sold_out", sold_out, 4'b0011);
    coin_1 = 1; coin_2 = 1; cyc(); coin_1 = 0; coin_2 = 0;
    select_valid = 1; item_sel = 2'd1; cyc(); select_valid = 0;
    check("s4_err_soldout", vend_error, 1);
    check("s4_credit_keep", credit, 3);
    check("s4_no_disp", item_dispensed, 0);
    cyc();
    check("s4_err_pulse", vend_error, 0);
    select_valid = 1; item_sel = 2'd2; cyc(); select_valid = 0;
    check("s4_err_credit", vend_error, 1);
    check("s4_credit_keep2", credit, 3);
    cancel = 1; cyc(); cancel = 0;
    change_ack = 1; repeat (3) cyc(); change_ack = 0;
    check("s4_drained", credit, 0);

    // Scenario 5: credit saturation by rejection
    coin_5 = 1; repeat (12) cyc(); coin_5 = 0;
    check("s5_credit60", credit, 60);
    coin_5 = 1; cyc(); coin_5 = 0;
    check("s5_reject65", coin_reject, 1);
    check("s5_credit_hold60", credit, 60);
    coin_2 = 1; cyc(); coin_2 = 0;
    check("s5_credit62", credit, 62);
    check("s5_no_reject", coin_reject, 0);
    coin_1 = 1; cyc(); coin_1 = 0;
    check("s5_credit63", credit, 63);
    coin_1 = 1; cyc(); coin_1 = 0;
    check("s5_reject64", coin_reject, 1);
    check("s5_credit_max", credit, 63);
    cancel = 1; cyc(); cancel = 0;
    coin_1 = 1; cyc(); coin_1 = 0;
    check("s5_reject_change", coin_reject, 1);
    check("s5_credit_change", credit, 63);
    change_ack = 1; repeat (63) cyc(); change_ack = 0;
    check("s5_drained", credit, 0);
    check("s5_idle", busy, 0);

    // Scenario 6: asynchronous reset mid-refund
    coin_2 = 1; repeat (2) cyc(); coin_2 = 0;
    cancel = 1; cyc(); cancel = 0;
    check("s6_change_valid", change_valid, 1);
    check("s6_credit4", credit, 4);
    #2 reset = 1'b0;
    #1;
    check("s6_async_valid", change_valid, 0);
    check("s6_async_credit", credit, 0);
    check("s6_async_busy", busy, 0);
    cyc();
    reset = 1'b1;
    cyc();
    check("s6_sold_out", sold_out, 4'b0000);
    coin_5 = 1; cyc(); coin_5 = 0;
    select_valid = 1; item_sel = 2'd0; cyc(); select_valid = 0;
    check("s6_restock_disp", item_dispensed, 1);
    cyc();
    check("s6_restock_credit", credit, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
